ahb_sram_subordinate: RTL and testbench
=======================================

Name: ahb_sram_subordinate

Overview:
- AHB subordinate that directly consumes the address/control and write data driven by the AHB manager stage.
- Backs a word-addressed SRAM array; supports byte, halfword and word transfers.
- Adds a programmable number of wait states.
- Returns a two-cycle ERROR response for illegal accesses.

Parameters:
ADDR_WIDTH, 32, width of addr
DATA_WIDTH, 32, width of wData/rData; 32 or 64
DEPTH_WORDS, 256, SRAM depth in DATA_WIDTH words; power of two
WAIT_STATES, 0, extra ready-low cycles per legal transfer (0..15)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
sel  input  1  decoder select for this subordinate
addr  input  ADDR_WIDTH  byte address (address phase)
write  input  1  1 = write, 0 = read (address phase)
size  input  3  transfer size, bytes = 1<<size (address phase)
trans  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
readyIn  input  1  bus-level ready; address phase accepted only when high
wData  input  DATA_WIDTH  write data (data phase)
ready  output  1  this subordinate's ready-out
resp  output  1  0 = OKAY, 1 = ERROR
rData  output  DATA_WIDTH  read data, valid when ready=1 and resp=0 in a read data phase

Behaviour:
- Reset: state=IDLE, ready=1, resp=0, rData=0, wait counter=0, captured controls cleared. SRAM contents are not reset.
- Address-phase accept: sel && readyIn && trans[1] on a rising edge.
  - Registers addr, write and size.
  - Computes legality and enters the data phase next cycle.
- IDLE/BUSY or sel=0 with readyIn high: no transfer; ready=1, resp=0 next cycle.
- Illegal access is any of:
  - size > log2(DATA_WIDTH/8)
  - addr not aligned to 1<<size
  - word index (addr >> log2(DATA_WIDTH/8)) >= DEPTH_WORDS
- States: IDLE, WAIT, ERR1, ERR2.
- IDLE on accept:
  - Legal and WAIT_STATES=0: stay IDLE. The data phase completes in the next cycle with ready=1, resp=0.
  - Legal and WAIT_STATES>0: go to WAIT with counter=WAIT_STATES.
  - Illegal: go to ERR1.
- WAIT: ready=0, counter decrements each cycle. When the counter reaches 0, go to IDLE, where the completing cycle has ready=1.
- ERR1: ready=0, resp=1, then ERR2.
- ERR2: ready=1, resp=1, then IDLE. A new address phase may be accepted in ERR2 when readyIn=1.
- Writes:
  - Performed on the completing data-phase edge (ready=1, resp=0) using wData.
  - Byte enables cover the (1<<size) bytes starting at lane addr[log2(DATA_WIDTH/8)-1:0], little-endian.
  - Other bytes are unchanged.
- Reads:
  - rData is the full stored word at the captured index, on the completing cycle.
  - Stale lanes are permitted; rData holds its last value otherwise.
- Pipelining: an address phase may be accepted in the same cycle a previous data phase completes. Back-to-back zero-wait NONSEQ/SEQ transfers sustain one transfer per cycle.
- Read-after-write to the same word in consecutive transfers must return the new data; write-port and read-port timing must guarantee this.
- Reset mid-transfer: reset wins. Go to IDLE, ready=1, any pending write is dropped.
- No lock, protection or burst-boundary checking; burst sequencing is the manager's job.

Optional Feature:
- Macro AHB_SRAM_SUB_RO_REGION_EN.
- Defined: parameters RO_BASE (default 0) and RO_LIMIT (default 15) give an inclusive word-index range. Writes into that range are illegal (ERR1/ERR2, memory unchanged); reads there are legal.
- Undefined: the parameters and logic are absent; all in-range writes are legal.

Decomposition:
- AHBCommon_pkg gains:
  - trans encodings TRANS_IDLE/BUSY/NONSEQ/SEQ (TRANS_IDLE already exists)
  - RESP_OKAY/RESP_ERROR
  - typedef ahb_sub_state_t {SUB_IDLE, SUB_WAIT, SUB_ERR1, SUB_ERR2}
  - a function returning the byte-enable mask from size and lane offset
- One sub-module, ahb_sram_bank:
  - byte-enabled single-port array with synchronous write
  - combinational read of the registered index
  - write-first forwarding

Test Plan:
1. WAIT_STATES=0: NONSEQ write addr=0x10 size=2 wData=0xDEADBEEF, then NONSEQ read 0x10 → ready=1 both data phases, resp=0, rData=0xDEADBEEF.
2. Byte write addr=0x11 size=0 wData=0x0000AA00 over 0xDEADBEEF; read 0x10 → rData=0xDEADAAEF.
3. WAIT_STATES=2: read 0x10 → ready low exactly 2 cycles, then high with correct data; total data phase 3 cycles.
4. Read addr=0x400 (DEPTH_WORDS=256), then misaligned addr=0x2 size=2 → each gives ready=0/resp=1 then ready=1/resp=1; memory unchanged.
5. Back-to-back SEQ writes 0x20,0x24,0x28,0x2C, then reads → one transfer per cycle, data matches.
6. Assert reset during WAIT of a write → next cycle ready=1, resp=0; target word unchanged. With AHB_SRAM_SUB_RO_REGION_EN, write word 5 → ERROR; read word 5 → OKAY.

Source files
------------

// File: rtl/AHBCommon_pkg.sv
// Shared AHB encodings, subordinate FSM state type and byte-enable helper.
package AHBCommon_pkg;

    // HTRANS encodings
    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    // HRESP encodings
    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        SUB_IDLE,
        SUB_WAIT,
        SUB_ERR1,
        SUB_ERR2
    } ahb_sub_state_t;

    // Little-endian byte-enable mask for (1<<size) bytes starting at lane.
    // Sized for up to 8 byte lanes; callers use the low DATA_WIDTH/8 bits.
    function automatic logic [7:0] byte_enable(input logic [2:0] xfer_size,
                                               input logic [2:0] lane);
        logic [7:0] base;
        case (xfer_size)
            3'd0:    base = 8'h01;
            3'd1:    base = 8'h03;
            3'd2:    base = 8'h0F;
            3'd3:    base = 8'hFF;
            default: base = 8'h00;
        endcase
        return base << lane;
    endfunction

endpackage

// File: rtl/ahb_sram_bank.sv
// Byte-enabled single-port SRAM: synchronous write, combinational read of the
// (externally registered) index, write-first forwarding of same-cycle writes.
module ahb_sram_bank #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 256,
    localparam int unsigned NUM_BYTES  = DATA_WIDTH / 8,
    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [NUM_BYTES-1:0]  be,
    input  logic [IDX_W-1:0]      index,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    // Byte-lane write on the rising edge; contents are never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < int'(NUM_BYTES); b++) begin
                if (be[b]) begin
                    mem[index][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read the stored word, overlaying bytes being written this cycle.
    always_comb begin
        rdata = mem[index];
        if (we) begin
            for (int b = 0; b < int'(NUM_BYTES); b++) begin
                if (be[b]) begin
                    rdata[b*8 +: 8] = wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/ahb_sram_subordinate.sv
// AHB SRAM subordinate with programmable wait states and two-cycle ERROR.
// Optional macro AHB_SRAM_SUB_RO_REGION_EN adds a read-only word-index range
// [RO_BASE, RO_LIMIT]; writes there are answered with ERROR.
module ahb_sram_subordinate
    import AHBCommon_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 0
`ifdef AHB_SRAM_SUB_RO_REGION_EN
    ,
    parameter int unsigned RO_BASE     = 0,
    parameter int unsigned RO_LIMIT    = 15
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sel,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  write,
    input  logic [2:0]            size,
    input  logic [1:0]            trans,
    input  logic                  readyIn,
    input  logic [DATA_WIDTH-1:0] wData,
    output logic                  ready,
    output logic                  resp,
    output logic [DATA_WIDTH-1:0] rData
);

    localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
    localparam int unsigned LANE_W    = $clog2(NUM_BYTES);
    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);

    ahb_sub_state_t        state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  pend_q, pend_d;   // legal data phase outstanding
    logic [IDX_W-1:0]      idx_q;
    logic [LANE_W-1:0]     lane_q;
    logic                  write_q;
    logic [2:0]            size_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  accept;
    logic                  legal;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [7:0]            align_mask;
    logic                  complete;
    logic                  bank_we;
    logic [7:0]            be_full;
    logic [NUM_BYTES-1:0]  be;
    logic [DATA_WIDTH-1:0] bank_rdata;
    logic                  unused_sig;

    assign unused_sig = ^{be_full, trans[0]};

    // Address-phase decode and legality check.
    always_comb begin
        accept     = sel && readyIn && trans[1] && ready;
        word_idx   = addr >> LANE_W;
        align_mask = (8'd1 << size) - 8'd1;
        legal      = (size <= 3'(LANE_W))
                  && ((addr[7:0] & align_mask) == 8'd0)
                  && (word_idx < ADDR_WIDTH'(DEPTH_WORDS));
`ifdef AHB_SRAM_SUB_RO_REGION_EN
        // Unsigned wrap turns the two-sided range test into one compare.
        if (write && ((word_idx - ADDR_WIDTH'(RO_BASE))
                      <= ADDR_WIDTH'(RO_LIMIT - RO_BASE))) begin
            legal = 1'b0;
        end
`endif
    end

    // State register and captured address-phase controls.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SUB_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            idx_q   <= '0;
            lane_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            rdata_q <= rData;
            if (accept) begin
                idx_q   <= word_idx[IDX_W-1:0];
                lane_q  <= addr[LANE_W-1:0];
                write_q <= write;
                size_q  <= size;
            end
        end
    end

    // Next-state logic; IDLE and ERR2 both present ready=1 and may accept.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        unique case (state_q)
            SUB_IDLE, SUB_ERR2: begin
                state_d = SUB_IDLE;
                pend_d  = 1'b0;
                if (accept) begin
                    if (!legal) begin
                        state_d = SUB_ERR1;
                    end else begin
                        pend_d = 1'b1;
                        if (WAIT_STATES != 0) begin
                            state_d = SUB_WAIT;
                            cnt_d   = 4'(WAIT_STATES);
                        end
                    end
                end
            end
            SUB_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = SUB_IDLE;
                end
            end
            SUB_ERR1: state_d = SUB_ERR2;
            default:  state_d = SUB_IDLE;
        endcase
    end

    // Outputs: ready/resp from state, memory strobes on the completing cycle.
    always_comb begin
        ready = 1'b1;
        resp  = RESP_OKAY;
        unique case (state_q)
            SUB_WAIT: ready = 1'b0;
            SUB_ERR1: begin
                ready = 1'b0;
                resp  = RESP_ERROR;
            end
            SUB_ERR2: resp = RESP_ERROR;
            default: ;
        endcase
        complete = (state_q == SUB_IDLE) && pend_q;
        // Reset wins over a write completing on the same edge.
        bank_we  = complete && write_q && !reset;
        be_full  = byte_enable(size_q, 3'(lane_q));
        be       = be_full[NUM_BYTES-1:0];
        rData    = (complete && !write_q) ? bank_rdata : rdata_q;
    end

    ahb_sram_bank #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_bank (
        .clk   (clk),
        .we    (bank_we),
        .be    (be),
        .index (idx_q),
        .wdata (wData),
        .rdata (bank_rdata)
    );

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// Directed bench: dut0 has zero wait states, dut1 has two.
module tb_ahb_sram_subordinate;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  sel_v = 2'b00;
    logic [31:0] addr = '0;
    logic        write = 1'b0;
    logic [2:0]  size = '0;
    logic [1:0]  trans = 2'b00;
    logic [31:0] wData = '0;
    logic [1:0]  rdy_v, rsp_v;
    logic [31:0] rdata0, rdata1;

    int          n_checks = 0;
    int          n_pass = 0;
    int          lows;
    logic        rsp, fr;
    logic [31:0] rd;

    always #5 clk = ~clk;

    ahb_sram_subordinate #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(256), .WAIT_STATES(0)
`ifdef AHB_SRAM_SUB_RO_REGION_EN
        , .RO_BASE(5), .RO_LIMIT(5)
`endif
    ) u_dut0 (
        .clk(clk), .reset(reset), .sel(sel_v[0]), .addr(addr), .write(write),
        .size(size), .trans(trans), .readyIn(rdy_v[0]), .wData(wData),
        .ready(rdy_v[0]), .resp(rsp_v[0]), .rData(rdata0)
    );

    ahb_sram_subordinate #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(256), .WAIT_STATES(2)
`ifdef AHB_SRAM_SUB_RO_REGION_EN
        , .RO_BASE(5), .RO_LIMIT(5)
`endif
    ) u_dut1 (
        .clk(clk), .reset(reset), .sel(sel_v[1]), .addr(addr), .write(write),
        .size(size), .trans(trans), .readyIn(rdy_v[1]), .wData(wData),
        .ready(rdy_v[1]), .resp(rsp_v[1]), .rData(rdata1)
    );

    // One NONSEQ transfer with an idle cycle before it; reports the number of
    // ready-low data-phase cycles, resp on first and last data-phase cycles.
    task automatic xfer(input int d, input logic [31:0] a, input logic w,
                        input logic [2:0] sz, input logic [31:0] wd,
                        output int nlow, output logic last_rsp,
                        output logic first_rsp, output logic [31:0] rdat);
        logic done;
        @(posedge clk); #1;
        sel_v = 2'b00; sel_v[d] = 1'b1;
        addr = a; write = w; size = sz; trans = 2'b10;
        @(posedge clk); #1;
        sel_v = 2'b00; trans = 2'b00; wData = wd;
        nlow = 0; done = 1'b0; last_rsp = 1'bx; first_rsp = 1'bx; rdat = 'x;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (i == 0) first_rsp = rsp_v[d];
            if (rdy_v[d]) begin
                done = 1'b1;
                last_rsp = rsp_v[d];
                rdat = (d == 0) ? rdata0 : rdata1;
            end else begin
                nlow++;
            end
        end
        if (!done) nlow = 99;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (rdy_v[d] !== 1'b1 || rsp_v[d] !== 1'b0)
                $display("FAIL reset_ready_resp dut%0d got %b/%b exp 1/0", d, rdy_v[d], rsp_v[d]);
            else n_pass++;
        end
        n_checks++;
        if (rdata0 !== 32'h0 || rdata1 !== 32'h0)
            $display("FAIL reset_rdata got %h/%h exp 0", rdata0, rdata1);
        else n_pass++;
        @(posedge clk); #1 reset = 1'b0;
        // BUSY with sel and NONSEQ without sel must not start a transfer.
        sel_v = 2'b01; trans = 2'b01; addr = 32'h3; size = 3'd2;
        @(posedge clk); #1 sel_v = 2'b00; trans = 2'b10;
        @(negedge clk);
        n_checks++;
        if (rdy_v[0] !== 1'b1 || rsp_v[0] !== 1'b0)
            $display("FAIL busy_no_xfer got %b/%b exp 1/0", rdy_v[0], rsp_v[0]);
        else n_pass++;
        @(posedge clk); #1 trans = 2'b00;
        @(negedge clk);
        n_checks++;
        if (rdy_v[0] !== 1'b1 || rsp_v[0] !== 1'b0)
            $display("FAIL nosel_no_xfer got %b/%b exp 1/0", rdy_v[0], rsp_v[0]);
        else n_pass++;
    endtask

    task automatic test_basic();
        xfer(0, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF, lows, rsp, fr, rd);
        n_checks++;
        if (lows !== 0 || rsp !== 1'b0)
            $display("FAIL basic_write lows=%0d resp=%b exp 0/0", lows, rsp);
        else n_pass++;
        xfer(0, 32'h10, 1'b0, 3'd2, 32'h0, lows, rsp, fr, rd);
        n_checks++;
        if (lows !== 0 || rsp !== 1'b0 || rd !== 32'hDEADBEEF)
            $display("FAIL basic_read lows=%0d resp=%b rdata=%h exp 0/0/deadbeef", lows, rsp, rd);
        else n_pass++;
    endtask

    task automatic test_byte_lanes();
        xfer(0, 32'h11, 1'b1, 3'd0, 32'h0000AA00, lows, rsp, fr, rd);
        xfer(0, 32'h10, 1'b0, 3'd2, 32'h0, lows, rsp, fr, rd);
        n_checks++;
        if (rd !== 32'hDEADAAEF) $display("FAIL byte_write got %h exp deadaaef", rd);
        else n_pass++;
        xfer(0, 32'h12, 1'b1, 3'd1, 32'h12340000, lows, rsp, fr, rd);
        xfer(0, 32'h10, 1'b0, 3'd2, 32'h0, lows, rsp, fr, rd);
        n_checks++;
        if (rd !== 32'h1234AAEF) $display("FAIL half_write got %h exp 1234aaef", rd);
        else n_pass++;
    endtask

    task automatic test_wait_states();
        xfer(1, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF, lows, rsp, fr, rd);
        n_checks++;
        if (lows !== 2 || rsp !== 1'b0)
            $display("FAIL wait_write lows=%0d resp=%b exp 2/0", lows, rsp);
        else n_pass++;
        xfer(1, 32'h10, 1'b0, 3'd2, 32'h0, lows, rsp, fr, rd);
        n_checks++;
        if (lows !== 2 || rsp !== 1'b0 || rd !== 32'hDEADBEEF)
            $display("FAIL wait_read lows=%0d resp=%b rdata=%h exp 2/0/deadbeef", lows, rsp, rd);
        else n_pass++;
    endtask

    task automatic test_errors();
        xfer(0, 32'h0, 1'b1, 3'd2, 32'h11111111, lows, rsp, fr, rd);
        xfer(0, 32'h400, 1'b0, 3'd2, 32'h0, lows, rsp, fr, rd);
        n_checks++;
        if (lows !== 1 || fr !== 1'b1 || rsp !== 1'b1)
            $display("FAIL err_range lows=%0d resp=%b,%b exp 1/1,1", lows, fr, rsp);
        else n_pass++;
        xfer(0, 32'h2, 1'b1, 3'd2, 32'hFFFFFFFF, lows, rsp, fr, rd);
        n_checks++;
        if (lows !== 1 || fr !== 1'b1 || rsp !== 1'b1)
            $display("FAIL err_misalign lows=%0d resp=%b,%b exp 1/1,1", lows, fr, rsp);
        else n_pass++;
        xfer(0, 32'h1, 1'b1, 3'd1, 32'hFFFFFFFF, lows, rsp, fr, rd);
        n_checks++;
        if (lows !== 1 || rsp !== 1'b1)
            $display("FAIL err_half_misalign lows=%0d resp=%b exp 1/1", lows, rsp);
        else n_pass++;
        xfer(0, 32'h0, 1'b1, 3'd3, 32'hFFFFFFFF, lows, rsp, fr, rd);
        n_checks++;
        if (lows !== 1 || rsp !== 1'b1)
            $display("FAIL err_size lows=%0d resp=%b exp 1/1", lows, rsp);
        else n_pass++;
        xfer(0, 32'h0, 1'b0, 3'd2, 32'h0, lows, rsp, fr, rd);
        n_checks++;
        if (rsp !== 1'b0 || rd !== 32'h11111111)
            $display("FAIL err_mem_unchanged resp=%b rdata=%h exp 0/11111111", rsp, rd);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] wd [4];
        wd[0] = 32'h11223344; wd[1] = 32'h55667788;
        wd[2] = 32'h99AABBCC; wd[3] = 32'hDDEEFF00;
        @(posedge clk); #1;
        sel_v = 2'b01; write = 1'b1; size = 3'd2; trans = 2'b10; addr = 32'h20;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            wData = wd[i];
            if (i < 3) begin addr = 32'h20 + 32'(4 * (i + 1)); trans = 2'b11; end
            else begin sel_v = 2'b00; trans = 2'b00; end
            @(negedge clk);
            n_checks++;
            if (rdy_v[0] !== 1'b1 || rsp_v[0] !== 1'b0)
                $display("FAIL b2b_write%0d ready/resp %b/%b exp 1/0", i, rdy_v[0], rsp_v[0]);
            else n_pass++;
        end
        @(posedge clk); #1;
        sel_v = 2'b01; write = 1'b0; trans = 2'b10; addr = 32'h20;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i < 3) begin addr = 32'h20 + 32'(4 * (i + 1)); trans = 2'b11; end
            else begin sel_v = 2'b00; trans = 2'b00; end
            @(negedge clk);
            n_checks++;
            if (rdy_v[0] !== 1'b1 || rdata0 !== wd[i])
                $display("FAIL b2b_read%0d ready=%b rdata=%h exp 1/%h", i, rdy_v[0], rdata0, wd[i]);
            else n_pass++;
        end
        // Write immediately followed by a read of the same word.
        @(posedge clk); #1;
        sel_v = 2'b01; write = 1'b1; trans = 2'b10; addr = 32'h30;
        @(posedge clk); #1;
        wData = 32'hA5A55A5A; write = 1'b0; trans = 2'b10;
        @(posedge clk); #1;
        sel_v = 2'b00; trans = 2'b00;
        @(negedge clk);
        n_checks++;
        if (rdy_v[0] !== 1'b1 || rdata0 !== 32'hA5A55A5A)
            $display("FAIL raw ready=%b rdata=%h exp 1/a5a55a5a", rdy_v[0], rdata0);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        xfer(1, 32'h40, 1'b1, 3'd2, 32'hCAFEF00D, lows, rsp, fr, rd);
        @(posedge clk); #1;
        sel_v = 2'b10; addr = 32'h40; write = 1'b1; size = 3'd2; trans = 2'b10;
        @(posedge clk); #1;
        sel_v = 2'b00; trans = 2'b00; wData = 32'h0BADBEEF;
        @(negedge clk);
        n_checks++;
        if (rdy_v[1] !== 1'b0) $display("FAIL mid_wait ready=%b exp 0", rdy_v[1]);
        else n_pass++;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rdy_v[1] !== 1'b1 || rsp_v[1] !== 1'b0 || rdata1 !== 32'h0)
            $display("FAIL mid_reset ready/resp/rdata %b/%b/%h exp 1/0/0",
                     rdy_v[1], rsp_v[1], rdata1);
        else n_pass++;
        xfer(1, 32'h40, 1'b0, 3'd2, 32'h0, lows, rsp, fr, rd);
        n_checks++;
        if (rsp !== 1'b0 || rd !== 32'hCAFEF00D)
            $display("FAIL mid_dropped resp=%b rdata=%h exp 0/cafef00d", rsp, rd);
        else n_pass++;
    endtask

`ifdef AHB_SRAM_SUB_RO_REGION_EN
    task automatic test_ro_region();
        xfer(0, 32'h14, 1'b1, 3'd2, 32'h77777777, lows, rsp, fr, rd);
        n_checks++;
        if (lows !== 1 || fr !== 1'b1 || rsp !== 1'b1)
            $display("FAIL ro_write lows=%0d resp=%b,%b exp 1/1,1", lows, fr, rsp);
        else n_pass++;
        xfer(0, 32'h14, 1'b0, 3'd2, 32'h0, lows, rsp, fr, rd);
        n_checks++;
        if (lows !== 0 || rsp !== 1'b0)
            $display("FAIL ro_read lows=%0d resp=%b exp 0/0", lows, rsp);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_byte_lanes();
        test_wait_states();
        test_errors();
        test_back_to_back();
        test_reset_mid();
`ifdef AHB_SRAM_SUB_RO_REGION_EN
        test_ro_region();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
